uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the SoPC data bus, a sibling slave of the data RAM. The core's load/store port drives it directly: stores queue bytes into an internal FIFO, and an FSM serialises them as 8N1 frames on `tx`. A level interrupt signals when all queued data has drained; the top level ORs it with the timer interrupt into the core's `int_i`.

---
 rtl/uart_tx_mmio_pkg.sv | 27 ++
 rtl/uart_tx_mmio_fifo.sv | 47 ++++
 rtl/uart_tx_mmio.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions, FSM states, divisor helper.
package uart_tx_mmio_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_BAUDDIV = 2'd3;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // A programmed divisor of 0 is treated as 1 cycle per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous byte FIFO for the UART transmitter.
// Ports: clk, rst (async active-low), push/din, pop/dout, full, empty, count.
module uart_tx_mmio_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when a slot frees in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and drain interrupt.
// Ports: clk, rst (async active-low), bus ce/we/addr/sel/data_i/data_o, tx, irq.
import uart_tx_mmio_pkg::*;

module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic        hit;
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  reg_sel;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic [31:0] count32;
    logic [3:0]  cnt4;
    logic [7:0]  fifo_dout;
    logic        enable;
    logic        irq_en;
    logic        overflow;
    logic [15:0] div;
    logic [15:0] reload;
    state_t      state;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic [15:0] baud_cnt;
    logic        bit_end;
    logic        busy;
    logic [31:0] status;
    logic        unused;

    assign unused  = &{1'b0, addr[1:0], sel[3:2], data_i[31:16]};

    assign hit     = ce && (addr[31:4] == BASE_ADDR[31:4]);
    assign rd_en   = hit & ~we;
    assign wr_en   = hit & we;
    assign reg_sel = addr[3:2];
    assign push    = wr_en && (reg_sel == REG_TXDATA) && sel[0];

    uart_tx_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (data_i[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign busy    = (state != S_IDLE);
    assign bit_end = (baud_cnt == 16'd0);
    assign reload  = eff_div(div) - 16'd1;
    // Pop either from idle or at the end of a stop bit for back-to-back frames.
    assign pop     = enable & ~empty &
                     ((state == S_IDLE) | ((state == S_STOP) & bit_end));

    assign count32 = 32'(count);
    assign cnt4    = (count32 > 32'd15) ? 4'hf : count32[3:0];
    assign status  = {24'b0, cnt4, overflow, busy, empty, full};

    always_comb begin
        data_o = '0;
        if (rd_en) begin
            unique case (reg_sel)
                REG_TXDATA:  data_o = '0;
                REG_STATUS:  data_o = status;
                REG_CTRL:    data_o = {30'b0, irq_en, enable};
                REG_BAUDDIV: data_o = {16'b0, div};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable   <= 1'b0;
            irq_en   <= 1'b0;
            div      <= DIV_RESET;
            overflow <= 1'b0;
        end else begin
            if (wr_en && (reg_sel == REG_CTRL) && sel[0]) begin
                enable <= data_i[0];
                irq_en <= data_i[1];
            end
            if (wr_en && (reg_sel == REG_BAUDDIV)) begin
                if (sel[0]) div[7:0]  <= data_i[7:0];
                if (sel[1]) div[15:8] <= data_i[15:8];
            end
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (wr_en && (reg_sel == REG_STATUS) &&
                     sel[0] && data_i[ST_OVF])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else begin
            // Divisor is sampled at each bit boundary, so changes
            // land on the next bit.
            if (state == S_IDLE) begin
                if (pop) baud_cnt <= reload;
            end else if (bit_end) begin
                baud_cnt <= reload;
            end else begin
                baud_cnt <= baud_cnt - 16'd1;
            end

            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg <= fifo_dout;
                        state <= S_START;
                        tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shreg <= fifo_dout;
                            state <= S_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq <= 1'b0;
        else      irq <= irq_en & empty & ~busy;
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: a monitor decodes tx frames
// and checks them against bytes queued by the stimulus process.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        tx;
    logic        irq;

    uart_tx_mmio #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8),
        .DIV_RESET  (16'd434)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .we     (we),
        .addr   (addr),
        .sel    (sel),
        .data_i (data_i),
        .data_o (data_o),
        .tx     (tx),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         starts[$];
    int         mon_div = 434;
    logic       prev_tx = 1'b1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wr(logic [1:0] r, logic [31:0] d, logic [3:0] s);
        ce = 1'b1; we = 1'b1; addr = BASE | {28'b0, r, 2'b0};
        data_i = d; sel = s;
        @(negedge clk);
        ce = 1'b0; we = 1'b0; sel = '0;
    endtask

    task automatic rd(logic [1:0] r, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = BASE | {28'b0, r, 2'b0};
        #1 d = data_o;
        ce = 1'b0;
    endtask

    task automatic rchk(string name, logic [1:0] r, logic [31:0] req);
        logic [31:0] v;
        rd(r, v);
        chk(name, v, req);
    endtask

    task automatic push(logic [7:0] b);
        wr(2'd0, {24'b0, b}, 4'h1);
        exp_q.push_back(b);
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(string name);
        logic [31:0] s;
        int n = 0;
        rd(2'd1, s);
        while (s[2:1] != 2'b01 && n < 3000) begin
            @(negedge clk);
            rd(2'd1, s);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL %s timeout status=%0h required=idle", name, s);
        end
        @(negedge clk);
    endtask

    // Frame monitor: samples every cycle of a frame at the falling clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && prev_tx === 1'b1 && tx === 1'b0) begin
                int d;
                logic [9:0] fr;
                bit ok;
                bit ab;
                logic [7:0] e;
                d = mon_div; ok = 1'b1; ab = 1'b0; fr = '0;
                starts.push_back(cyc);
                for (int b = 0; b < 10; b++) begin
                    for (int s = 0; s < d; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge clk);
                        if (!rst) ab = 1'b1;
                        if (s == 0) fr[b] = tx;
                        else if (tx !== fr[b]) ok = 1'b0;
                    end
                end
                if (!ab) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL frame_unexpected actual=%0h required=none",
                                 fr[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        if (!ok || fr[0] !== 1'b0 || fr[9] !== 1'b1 ||
                            fr[8:1] !== e) begin
                            failures++;
                            $display("FAIL frame actual=%0h required=%0h start=%b stop=%b uniform=%0d",
                                     fr[8:1], e, fr[0], fr[9], ok);
                        end
                    end
                end
            end
            prev_tx = tx;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int bad;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_tx", tx, 1);
        chk("rst_irq", irq, 0);
        rchk("rst_status", 1, 32'h2);
        rchk("rst_ctrl", 2, 0);
        rchk("rst_div", 3, 434);
        rchk("txdata_rd", 0, 0);
        @(negedge clk);
        addr = BASE | 32'h4; we = 1'b0; ce = 1'b0;
        #1 chk("no_ce", data_o, 0);
        addr = 32'h2000_0004; ce = 1'b1;
        #1 chk("bad_addr", data_o, 0);
        ce = 1'b0;
        @(negedge clk);

        // Lane enables
        wr(3, 32'h0000_0705, 4'h2);
        rchk("div_lane1", 3, 32'h0000_01b2 & 32'h0 | 32'h0000_07b2);
        @(negedge clk);
        wr(0, 32'h55, 4'h0);
        rchk("txdata_nolane", 1, 32'h2);
        @(negedge clk);

        // Single frame 0xA5, BAUDDIV=4
        wr(3, 4, 4'h3);
        mon_div = 4;
        wr(2, 1, 4'h1);
        starts.delete();
        push(8'hA5);
        w = cyc;
        rchk("a5_status", 1, 32'h10);
        wait_idle("a5_idle");
        chk("a5_nstart", starts.size(), 1);
        chk("a5_start", starts[0], w + 1);

        // Three back-to-back frames
        starts.delete();
        push(8'h3C);
        w = cyc;
        push(8'h81);
        push(8'h7E);
        rchk("b2b_cnt2", 1, 32'h24);
        wait_cyc(w + 40);
        rchk("b2b_cnt2_late", 1, 32'h24);
        wait_cyc(w + 41);
        rchk("b2b_cnt1", 1, 32'h14);
        wait_cyc(w + 81);
        rchk("b2b_cnt0", 1, 32'h06);
        wait_idle("b2b_idle");
        chk("b2b_nstart", starts.size(), 3);
        chk("b2b_start0", starts[0], w + 1);
        chk("b2b_gap1", starts[1] - starts[0], 40);
        chk("b2b_gap2", starts[2] - starts[0], 80);

        // Drain interrupt
        starts.delete();
        push(8'hC3);
        w = cyc;
        wr(2, 3, 4'h1);
        bad = 0;
        while (cyc < w + 42) begin
            if (irq !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("irq_frame_low", bad, 0);
        chk("irq_rise", irq, 1);
        push(8'h18);
        chk("irq_hold", irq, 1);
        @(negedge clk);
        chk("irq_fall_push", irq, 0);
        wait_idle("irq_idle");
        chk("irq_idle", irq, 1);
        wr(2, 1, 4'h1);
        chk("irq_hold_ctrl", irq, 1);
        @(negedge clk);
        chk("irq_fall_en", irq, 0);

        // Enable cleared mid-frame with two bytes queued
        starts.delete();
        push(8'h11);
        w = cyc;
        push(8'h22);
        push(8'h33);
        wait_cyc(w + 9);
        wr(2, 0, 4'h1);
        wait_cyc(w + 42);
        bad = 0;
        while (cyc < w + 70) begin
            if (tx !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("dis_line_idle", bad, 0);
        chk("dis_nstart", starts.size(), 1);
        rchk("dis_status", 1, 32'h20);
        @(negedge clk);
        wr(2, 1, 4'h1);
        w = cyc;
        wait_cyc(w + 2);
        chk("reen_nstart", starts.size(), 2);
        chk("reen_start", starts[1], w + 1);
        wait_idle("reen_idle");

        // BAUDDIV=0 behaves as 1
        wr(3, 0, 4'h3);
        mon_div = 1;
        rchk("div0_rd", 3, 0);
        @(negedge clk);
        starts.delete();
        push(8'h5A);
        w = cyc;
        push(8'hC0);
        wait_idle("div0_idle");
        chk("div0_nstart", starts.size(), 2);
        chk("div0_start", starts[0], w + 1);
        chk("div0_gap", starts[1] - starts[0], 10);

        // Overflow while disabled
        wr(3, 4, 4'h3);
        mon_div = 4;
        wr(2, 0, 4'h1);
        for (int i = 0; i < 9; i++) wr(0, 32'h40 + i, 4'h1);
        rchk("ovf_status", 1, 32'h89);
        @(negedge clk);
        wr(1, 32'h8, 4'h1);
        rchk("ovf_clear", 1, 32'h81);
        @(negedge clk);

        // Reset in the middle of the DATA phase (bit2 of 0x40 is 0)
        starts.delete();
        wr(2, 1, 4'h1);
        w = cyc;
        wait_cyc(w + 13);
        chk("pre_rst_tx", tx, 0);
        rst = 1'b0;
        #1 chk("rst_mid_tx", tx, 1);
        rchk("rst_mid_status", 1, 32'h2);
        rchk("rst_mid_div", 3, 434);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rchk("post_rst_ctrl", 2, 0);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
